// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single in-order memory port.
// An in-flight tag FIFO records each grant's source and steers responses back to it.
module mem_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_DPRI = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    output logic        imemreq_rdy,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    output logic        dmemreq_rdy,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    output logic [31:0] dmemresp_data,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic        memreq_type,
    output logic [31:0] memreq_addr,
    output logic [31:0] memreq_wdata,
    input  logic        memresp_val,
    input  logic [31:0] memresp_data,
    output logic        err_orphan
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_DPRI + 1);

    typedef struct packed {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [DEPTH-1:0] tags;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    dstreak;
    logic             can_issue, sel_data, fire, pop;
    req_t             req;

    always_comb begin
        can_issue = (count < CW'(DEPTH)) & ~rst;
        // Data wins ties until the streak saturates, then fetch gets one grant.
        sel_data  = dmemreq_val & (~imemreq_val | (dstreak != SW'(MAX_DPRI)));
        memreq_val = can_issue & (imemreq_val | dmemreq_val);
        fire       = memreq_val & memreq_rdy;
        req = '0;
        if (!rst) begin
            if (sel_data)
                req = '{dmemreq_type, dmemreq_addr, dmemreq_wdata};
            else if (imemreq_val)
                req = '{1'b0, imemreq_addr, 32'h0};
        end
        memreq_type  = req.typ;
        memreq_addr  = req.addr;
        memreq_wdata = req.wdata;
        dmemreq_rdy  = fire & sel_data;
        imemreq_rdy  = fire & ~sel_data;
        pop           = memresp_val & (count != '0) & ~rst;
        imemresp_val  = pop & ~tags[rd_ptr];
        dmemresp_val  = pop & tags[rd_ptr];
        imemresp_data = rst ? 32'h0 : memresp_data;
        dmemresp_data = rst ? 32'h0 : memresp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            dstreak    <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (fire) begin
                tags[wr_ptr] <= sel_data;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({fire, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (memresp_val && count == '0)
                err_orphan <= 1'b1;
            if (fire && sel_data && imemreq_val) begin
                if (dstreak != SW'(MAX_DPRI))
                    dstreak <= dstreak + SW'(1);
            end else if ((fire && !sel_data) || !imemreq_val) begin
                dstreak <= '0;
            end
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, in-order, variable-latency memory between the processor's instruction-fetch port and data port. Selects at most one request per cycle, forwards it combinationally, records its source in an in-flight tag FIFO, and routes each in-order response back to the port that issued it. Sits between the pipeline's imem/dmem request and response ports and the unified memory. Data requests have priority, with a bounded-starvation guard for fetch.

## Interface
- DEPTH, 4: max outstanding requests, power of two, ≥2.
- MAX_DPRI, 3: max consecutive data grants while a fetch waits, ≥1.
- clk  in  1  clock; all state rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- imemreq_val  in  1  fetch request valid.
- imemreq_rdy  out  1  fetch request accepted this cycle.
- imemreq_addr  in  32  fetch byte address.
- imemresp_val  out  1  fetch response valid.
- imemresp_data  out  32  fetch response data.
- dmemreq_val  in  1  data request valid.
- dmemreq_rdy  out  1  data request accepted this cycle.
- dmemreq_type  in  1  0 = read, 1 = write.
- dmemreq_addr  in  32  data byte address.
- dmemreq_wdata  in  32  store data.
- dmemresp_val  out  1  data response valid; also returned for writes.
- dmemresp_data  out  32  load data; don't-care for writes.
- memreq_val  out  1  memory request valid.
- memreq_rdy  in  1  memory accepts request.
- memreq_type  out  1  0 = read, 1 = write.
- memreq_addr  out  32  forwarded address.
- memreq_wdata  out  32  forwarded store data.
- memresp_val  in  1  memory response valid; in request order, always accepted.
- memresp_data  in  32  memory response data.
- err_orphan  out  1  sticky: a response arrived with no request outstanding.

## Operation
- State:
  - Tag FIFO of DEPTH 1-bit source IDs (0 = fetch, 1 = data), with read and write pointers and a count of width clog2(DEPTH)+1.
  - dstreak counter, 0..MAX_DPRI.
  - err_orphan flag.
- can_issue = (count < DEPTH) & ~rst. A full FIFO blocks all grants, even in a cycle where a pop also occurs.
- Selection, computed combinationally each cycle:
  - If only one port is valid, that port is selected.
  - If both are valid, data is selected unless dstreak == MAX_DPRI, in which case fetch is selected.
- memreq_val = can_issue & (imemreq_val | dmemreq_val).
- memreq_type, memreq_addr and memreq_wdata mux from the selected port. A fetch forces type = 0 and wdata = 0.
- Port ready signals:
  - The selected port's rdy = can_issue & memreq_rdy.
  - The other port's rdy = 0.
  - Both rdy = 0 when memreq_val = 0.
- Grant (fire) = memreq_val & memreq_rdy. On fire, push the selected port's source ID.
- On memresp_val with count > 0:
  - Pop the head.
  - Drive imemresp_val or dmemresp_val according to the head ID.
  - Both response data outputs carry memresp_data.
- On memresp_val with count == 0: no pop, no port response, and err_orphan is set.
- Push and pop in the same cycle: count is unchanged, and both pointers advance (mod DEPTH).
- dstreak update, per cycle:
  - Data fire while imemreq_val = 1: increment, saturating at MAX_DPRI.
  - Fetch fire, or imemreq_val = 0: clear to 0.
  - Otherwise: hold.
- Requesters must hold val and payload stable until rdy. The arbiter does not re-select mid-request unless dstreak forces it.
- Reset (async, any time, including mid-transaction): outstanding tags are discarded, and the pipeline is squashed/reset concurrently.
  - count, pointers, dstreak and err_orphan go to 0.
  - While rst = 1, all val and rdy outputs are 0.

## Timing
- Request path is combinational, zero added latency: a request fires the same cycle it is presented if memory is ready.
- Response path is combinational: port response in the same cycle as memresp_val.
- Fetch round-trip = memory latency exactly. Throughput is one grant per cycle.
- Worst-case fetch wait while data is continuously valid: MAX_DPRI data grants, then fetch.
- Reset values: every output 0 (memreq_type, memreq_addr and memreq_wdata = 0 when no port is valid).

## Test plan
- Single fetch, addr 0x200, 1-cycle memory returning 0x00A00093:
  - memreq_addr = 0x200 and imemreq_rdy = 1 in cycle 0.
  - imemresp_val = 1, data 0x00A00093, dmemresp_val = 0 in cycle 1.
- Simultaneous fetch 0x204 and store 0x1000/0xDEADBEEF:
  - The store fires first, with memreq_type = 1, then the fetch fires.
  - Responses route in order: data then fetch.
- Both ports continuously valid, MAX_DPRI = 3:
  - Grant sequence is D,D,D,I,D,D,D,I…
  - dstreak returns to 0 after each fetch grant.
- DEPTH = 4, memory holds responses for 10 cycles:
  - Exactly 4 grants are issued, then both rdy = 0.
  - After one response, one new grant occurs on the following cycle (not the pop cycle).
- Orphan: memresp_val with count = 0 → no port response, and err_orphan = 1 and stays 1 until rst.
- Assert rst with 3 requests outstanding:
  - All outputs are 0 immediately, asynchronously.
  - After release, a fresh fetch is granted and its response routes to fetch.
